// File: rtl/glitcbus_pkg.sv
// Shared types and helpers for the GLITC bus clock generator.
package glitcbus_pkg;

    typedef enum logic [1:0] {
        SEQ_RST    = 2'd0,
        SEQ_WAIT   = 2'd1,
        SEQ_LOCKED = 2'd2
    } seq_state_e;

    localparam int unsigned MIN_DIV = 2;

    // Periods below MIN_DIV cannot form a high and a low phase.
    function automatic int unsigned clamp_div(input int unsigned p);
        return (p < MIN_DIV) ? MIN_DIV : p;
    endfunction

endpackage

// File: rtl/glitcbus_dcm_reset_seq.sv
// DCM/PLL reset sequencer: lock synchroniser, reset/wait/locked FSM, saturating retry count.
module glitcbus_dcm_reset_seq
    import glitcbus_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dcm_locked_i,
    output logic       dcm_rst_o,
    output logic       locked_o,
    output logic [7:0] retries_o
);

    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    logic             sync1_q, sync2_q;
    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dcm_rst_q, locked_q;
    logic [7:0]       retries_q, retries_inc_c;

    assign retries_inc_c = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= SEQ_RST;
            cnt_q     <= '0;
            dcm_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            retries_q <= '0;
        end else begin
            sync1_q <= dcm_locked_i;
            sync2_q <= sync1_q;
            case (state_q)
                SEQ_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= SEQ_WAIT;
                        cnt_q     <= '0;
                        dcm_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SEQ_WAIT: begin
                    if (sync2_q) begin
                        state_q  <= SEQ_LOCKED;
                        locked_q <= 1'b1;
                    end else if (cnt_q == WAIT_LAST) begin
                        state_q   <= SEQ_RST;
                        cnt_q     <= '0;
                        dcm_rst_q <= 1'b1;
                        retries_q <= retries_inc_c;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SEQ_LOCKED: begin
                    if (!sync2_q) begin
                        state_q   <= SEQ_RST;
                        cnt_q     <= '0;
                        dcm_rst_q <= 1'b1;
                        locked_q  <= 1'b0;
                        retries_q <= retries_inc_c;
                    end
                end
                default: begin
                    state_q   <= SEQ_RST;
                    cnt_q     <= '0;
                    dcm_rst_q <= 1'b1;
                    locked_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dcm_rst_o = dcm_rst_q;
    assign locked_o  = locked_q;
    assign retries_o = retries_q;

endmodule

// File: rtl/glitcbus_clkgen_multi.sv
// GLITC bus clock generator: programmable period divider, per-channel phase and
// glitch-free enable, shadowed reconfiguration, and the DCM reset sequencer.
module glitcbus_clkgen_multi
    import glitcbus_pkg::*;
#(
    parameter int unsigned NUM_OUT      = 4,
    parameter int unsigned DIV_WIDTH    = 4,
    parameter int unsigned DEFAULT_DIV  = 2,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [DIV_WIDTH-1:0]           div_i,
    input  logic [NUM_OUT*DIV_WIDTH-1:0]   phase_i,
    input  logic                           load_i,
    input  logic [NUM_OUT-1:0]             en_i,
    input  logic                           dcm_locked_i,
    output logic                           ce_o,
    output logic [NUM_OUT-1:0]             GCLK,
    output logic                           cfg_pending_o,
    output logic                           dcm_rst_o,
    output logic                           locked_o,
    output logic [7:0]                     retries_o
);

    localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(clamp_div(DEFAULT_DIV));

    logic [DIV_WIDTH-1:0]                cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]                p_act_q, p_act_d, div_sh_q, p_new_c, half_c;
    logic [NUM_OUT-1:0][DIV_WIDTH-1:0]   ph_act_q, ph_act_d, ph_sh_q, ph_apply_c;
    logic                                pending_q, pending_d;
    logic                                ce_q;
    logic [NUM_OUT-1:0]                  gclk_q, gclk_d, en_act_q, en_d;
    logic                                boundary_c, apply_c;

    assign p_new_c    = DIV_WIDTH'(clamp_div(32'(div_sh_q)));
    assign half_c     = p_act_q >> 1;
    assign boundary_c = (cnt_q == p_act_q - DIV_WIDTH'(1));
    assign apply_c    = pending_q && boundary_c;

    // Per-channel phase-relative count, enable sampling and output decision.
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
        logic [DIV_WIDTH-1:0] ph_sh_c, rel_c;
        assign ph_sh_c       = ph_sh_q[i];
        assign ph_apply_c[i] = (ph_sh_c > p_new_c - DIV_WIDTH'(1)) ? p_new_c - DIV_WIDTH'(1) : ph_sh_c;
        assign rel_c         = (cnt_q >= ph_act_q[i]) ? cnt_q - ph_act_q[i]
                                                      : cnt_q + p_act_q - ph_act_q[i];
        assign en_d[i]       = (rel_c == '0) ? en_i[i] : en_act_q[i];
        assign gclk_d[i]     = en_d[i] && (rel_c < half_c);
    end

    always_comb begin
        cnt_d     = boundary_c ? '0 : cnt_q + DIV_WIDTH'(1);
        p_act_d   = apply_c ? p_new_c : p_act_q;
        ph_act_d  = apply_c ? ph_apply_c : ph_act_q;
        // A load in the apply cycle wins over the clear and waits for the next boundary.
        pending_d = load_i | (pending_q & ~apply_c);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            ce_q      <= 1'b0;
            gclk_q    <= '0;
            en_act_q  <= '0;
            p_act_q   <= RST_DIV;
            ph_act_q  <= '0;
            div_sh_q  <= DIV_WIDTH'(DEFAULT_DIV);
            ph_sh_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ce_q      <= (cnt_q == '0);
            gclk_q    <= gclk_d;
            en_act_q  <= en_d;
            p_act_q   <= p_act_d;
            ph_act_q  <= ph_act_d;
            pending_q <= pending_d;
            if (load_i) begin
                div_sh_q <= div_i;
                ph_sh_q  <= phase_i;
            end
        end
    end

    assign ce_o          = ce_q;
    assign GCLK          = gclk_q;
    assign cfg_pending_o = pending_q;

    glitcbus_dcm_reset_seq #(
        .RESET_CYCLES (RESET_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_seq (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .dcm_locked_i (dcm_locked_i),
        .dcm_rst_o    (dcm_rst_o),
        .locked_o     (locked_o),
        .retries_o    (retries_o)
    );

endmodule
